// File: rtl/bconv_engine.sv
// ============================================================================
// bconv_engine: 3x3 XNOR-popcount binary convolution over a square 1-bpp image
// read row-by-row from SRAM; one packed output row written per SRAM word.
// Optional macro BCONV_THRESHOLD_EN adds a run-time majority threshold input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bconv_engine #(
    parameter int                WIDTH    = 16,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] OUT_BASE = 'h100
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              go,
    input  logic [8:0]        weights,
`ifdef BCONV_THRESHOLD_EN
    input  logic [3:0]        threshold,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [WIDTH-1:0]  sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [WIDTH-1:0]  dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIM_RD  = 3'd1,
        DIM_CAP = 3'd2,
        ROW_RD  = 3'd3,
        ROW_CAP = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [8:0]       wt;
    logic [3:0]       thr;
    logic [4:0]       n_dim;
    logic [4:0]       rows;
    logic [WIDTH-1:0] win_old;
    logic [WIDTH-1:0] win_mid;
    logic [WIDTH-1:0] win [3];
    logic [WIDTH-1:0] row_out;

    // Reset asserts asynchronously but releases two clocks after reset_b rises.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // The row arriving on the read bus is the newest window row, so the output
    // row is computed before the window registers shift.
    assign win[0] = win_old;
    assign win[1] = win_mid;
    assign win[2] = sram_dut_read_data;

    always_comb begin
        row_out = '0;
        for (int c = 0; c < WIDTH - 2; c++) begin
            logic [3:0] m;
            m = 4'd0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    m = m + {3'b000, (win[i][c+j] ~^ wt[3*i+j])};
                end
            end
            row_out[c] = ((c + 3) <= int'(n_dim)) && (m >= thr);
        end
    end

`ifndef BCONV_THRESHOLD_EN
    assign thr = 4'd5;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            wt                     <= 9'd0;
`ifdef BCONV_THRESHOLD_EN
            thr                    <= 4'd0;
`endif
            n_dim                  <= 5'd0;
            rows                   <= 5'd0;
            win_old                <= '0;
            win_mid                <= '0;
            dut_sram_read_address  <= '0;
            dut_sram_write_address <= '0;
            dut_sram_write_data    <= '0;
            dut_sram_write_enable  <= 1'b0;
        end else begin
            done                   <= 1'b0;
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= '0;
            dut_sram_write_data    <= '0;
            case (state)
                IDLE: begin
                    if (go) begin
                        wt                    <= weights;
`ifdef BCONV_THRESHOLD_EN
                        thr                   <= threshold;
`endif
                        err                   <= 1'b0;
                        busy                  <= 1'b1;
                        dut_sram_read_address <= '0;
                        state                 <= DIM_RD;
                    end
                end
                DIM_RD: state <= DIM_CAP;
                DIM_CAP: begin
                    n_dim <= sram_dut_read_data[4:0];
                    rows  <= 5'd0;
                    if ((sram_dut_read_data[4:0] < 5'd3) ||
                        (int'(sram_dut_read_data[4:0]) > WIDTH)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dut_sram_read_address <= ADDR_W'(1);
                        state                 <= ROW_RD;
                    end
                end
                ROW_RD: state <= ROW_CAP;
                ROW_CAP: begin
                    win_old <= win_mid;
                    win_mid <= sram_dut_read_data;
                    rows    <= rows + 5'd1;
                    if (rows >= 5'd2) begin
                        dut_sram_write_enable  <= 1'b1;
                        dut_sram_write_address <= OUT_BASE + ADDR_W'(rows - 5'd2);
                        dut_sram_write_data    <= row_out;
                        state                  <= WRITE;
                    end else begin
                        dut_sram_read_address <= ADDR_W'(rows + 5'd2);
                        state                 <= ROW_RD;
                    end
                end
                WRITE: begin
                    if (rows == n_dim) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dut_sram_read_address <= ADDR_W'(rows + 5'd1);
                        state                 <= ROW_RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bconv_engine.sv
// ============================================================================
// tb_bconv_engine: directed self-checking bench for bconv_engine with an SRAM
// model. Define BCONV_THRESHOLD_EN to exercise the threshold input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bconv_engine;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        go;
    logic [8:0]  weights;
    logic [3:0]  threshold;
    logic        busy, done, err;
    logic [11:0] raddr, waddr;
    logic [15:0] rdata, wdata;
    logic        we;

    logic [15:0] mem [0:4095];
    logic [11:0] wa [0:15];
    logic [15:0] wd [0:15];
    int          nw, busy_cnt, done_cnt, viol;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    bconv_engine dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .go                     (go),
        .weights                (weights),
`ifdef BCONV_THRESHOLD_EN
        .threshold              (threshold),
`endif
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .dut_sram_read_address  (raddr),
        .sram_dut_read_data     (rdata),
        .dut_sram_write_address (waddr),
        .dut_sram_write_data    (wdata),
        .dut_sram_write_enable  (we)
    );

    task automatic load_image(input int n, input logic [15:0] even_row, input logic [15:0] odd_row);
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[0] = 16'(n);
        for (int r = 0; r < n; r++) mem[r+1] = (r % 2 == 0) ? even_row : odd_row;
    endtask

    // Starts one job and records busy cycles, done pulses and write strobes.
    task automatic run_job(input logic [8:0] w, input logic [3:0] th, input bit spam);
        bit fin;
        nw = 0; busy_cnt = 0; done_cnt = 0; viol = 0; fin = 1'b0;
        @(negedge clk);
        weights = w; threshold = th; go = 1'b1;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (we) begin
                if (nw < 16) begin
                    wa[nw] = waddr;
                    wd[nw] = wdata;
                end
                nw++;
            end else if (waddr !== 12'h000 || wdata !== 16'h0000) begin
                viol++;
            end
            go = (spam && !fin) ? ~go : 1'b0;
        end
        go = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, err, we} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {busy, done, err, we});
        end
        checks++;
        if (raddr !== 12'h000 || waddr !== 12'h000 || wdata !== 16'h0000) begin
            errors++; $display("FAIL reset_bus raddr=%h waddr=%h wdata=%h want 0", raddr, waddr, wdata);
        end
    endtask

    task automatic test_all_ones;
        load_image(4, 16'hFFFF, 16'hFFFF);
        run_job(9'h1FF, 4'd5, 1'b0);
        checks++;
        if (nw !== 2) begin errors++; $display("FAIL ones_nwrites got=%0d want=2", nw); end
        checks++;
        if (wa[0] !== 12'h100 || wd[0] !== 16'h0003) begin
            errors++; $display("FAIL ones_row0 got=%h:%h want=100:0003", wa[0], wd[0]);
        end
        checks++;
        if (wa[1] !== 12'h101 || wd[1] !== 16'h0003) begin
            errors++; $display("FAIL ones_row1 got=%h:%h want=101:0003", wa[1], wd[1]);
        end
        checks++;
        if (busy_cnt !== 13) begin errors++; $display("FAIL ones_busy got=%0d want=13", busy_cnt); end
        checks++;
        if (done_cnt !== 1 || err !== 1'b0) begin
            errors++; $display("FAIL ones_done done=%0d err=%b want 1,0", done_cnt, err);
        end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL ones_idle_bus got=%0d want=0", viol); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ones_after busy=%b done=%b want 0,0", busy, done);
        end
    endtask

    task automatic test_zero_weights;
        load_image(4, 16'hFFFF, 16'hFFFF);
        run_job(9'h000, 4'd5, 1'b0);
        checks++;
        if (nw !== 2 || wa[0] !== 12'h100 || wd[0] !== 16'h0000 || wa[1] !== 12'h101 || wd[1] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_w n=%0d %h:%h %h:%h want 2 100:0000 101:0000", nw, wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_alternating;
        logic [15:0] exp_row;
        load_image(8, 16'h5555, 16'hAAAA);
        run_job(9'h155, 4'd5, 1'b0);
        checks++;
        if (nw !== 6) begin errors++; $display("FAIL alt_nwrites got=%0d want=6", nw); end
        for (int r = 0; r < 6 && r < nw; r++) begin
            exp_row = (r % 2 == 0) ? 16'h0015 : 16'h002A;
            checks++;
            if (wa[r] !== 12'(12'h100 + r) || wd[r] !== exp_row) begin
                errors++; $display("FAIL alt_row%0d got=%h:%h want=%h:%h", r, wa[r], wd[r], 12'(12'h100 + r), exp_row);
            end
        end
        checks++;
        if (busy_cnt !== 25) begin errors++; $display("FAIL alt_busy got=%0d want=25", busy_cnt); end
    endtask

    task automatic test_invalid(input int n);
        load_image(n, 16'hFFFF, 16'hFFFF);
        run_job(9'h1FF, 4'd5, 1'b0);
        checks++;
        if (err !== 1'b1 || done_cnt !== 1) begin
            errors++; $display("FAIL inv%0d_err err=%b done=%0d want 1,1", n, err, done_cnt);
        end
        checks++;
        if (nw !== 0 || busy_cnt !== 3) begin
            errors++; $display("FAIL inv%0d_cost writes=%0d busy=%0d want 0,3", n, nw, busy_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inv%0d_sticky err=%b want 1", n, err); end
    endtask

    task automatic test_err_clear;
        load_image(4, 16'hFFFF, 16'hFFFF);
        run_job(9'h1FF, 4'd5, 1'b0);
        checks++;
        if (err !== 1'b0 || nw !== 2 || wd[0] !== 16'h0003) begin
            errors++; $display("FAIL err_clear err=%b writes=%0d d0=%h want 0,2,0003", err, nw, wd[0]);
        end
    endtask

    task automatic test_back_to_back;
        load_image(8, 16'h5555, 16'hAAAA);
        run_job(9'h155, 4'd5, 1'b1);
        checks++;
        if (nw !== 6 || busy_cnt !== 25 || done_cnt !== 1) begin
            errors++; $display("FAIL spam_job writes=%0d busy=%0d done=%0d want 6,25,1", nw, busy_cnt, done_cnt);
        end
        checks++;
        if (wd[0] !== 16'h0015 || wd[5] !== 16'h002A || wa[5] !== 12'h105) begin
            errors++; $display("FAIL spam_data d0=%h d5=%h a5=%h want 0015,002A,105", wd[0], wd[5], wa[5]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL spam_restart busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_write;
        bit hit;
        hit = 1'b0;
        load_image(8, 16'h5555, 16'hAAAA);
        @(negedge clk);
        weights = 9'h155; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (we) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_write_seen got=0 want=1"); end
        reset_b = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, we} !== 4'b0000 || raddr !== 12'h000 || waddr !== 12'h000 || wdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_abort flags=%b raddr=%h waddr=%h wdata=%h want all 0", {busy, done, err, we}, raddr, waddr, wdata);
        end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            errors++; $display("FAIL rst_idle busy=%b we=%b want 0,0", busy, we);
        end
        load_image(4, 16'hFFFF, 16'hFFFF);
        run_job(9'h1FF, 4'd5, 1'b0);
        checks++;
        if (nw !== 2 || wd[1] !== 16'h0003 || busy_cnt !== 13) begin
            errors++; $display("FAIL rst_recover writes=%0d d1=%h busy=%0d want 2,0003,13", nw, wd[1], busy_cnt);
        end
    endtask

`ifdef BCONV_THRESHOLD_EN
    task automatic test_threshold;
        load_image(4, 16'hFFFF, 16'hFFFF);
        run_job(9'h0F0, 4'd4, 1'b0);
        checks++;
        if (nw !== 2 || wd[0] !== 16'h0003 || wd[1] !== 16'h0003) begin
            errors++; $display("FAIL thr4 writes=%0d d0=%h d1=%h want 2,0003,0003", nw, wd[0], wd[1]);
        end
        run_job(9'h0F0, 4'd5, 1'b0);
        checks++;
        if (nw !== 2 || wd[0] !== 16'h0000 || wd[1] !== 16'h0000) begin
            errors++; $display("FAIL thr5 writes=%0d d0=%h d1=%h want 2,0000,0000", nw, wd[0], wd[1]);
        end
        run_job(9'h000, 4'd0, 1'b0);
        checks++;
        if (nw !== 2 || wd[0] !== 16'h0003) begin
            errors++; $display("FAIL thr0 writes=%0d d0=%h want 2,0003", nw, wd[0]);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        reset_b = 1'b0; go = 1'b0; weights = 9'h000; threshold = 4'd5;
        repeat (3) @(negedge clk);
        test_reset;
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        test_all_ones;
        test_zero_weights;
        test_alternating;
        test_invalid(2);
        test_err_clear;
        test_invalid(17);
        test_err_clear;
        test_back_to_back;
        test_reset_mid_write;
`ifdef BCONV_THRESHOLD_EN
        test_threshold;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bconv_engine.md
Name: bconv_engine

Overview:
Binary-convolution datapath that runs one job per controller handshake. It reads a 1-bit-per-pixel square image row-by-row from the input SRAM and applies a 3x3 XNOR-popcount kernel with a majority threshold. It writes one packed output row per SRAM word. It sits directly downstream of the controller: it starts on `go` and owns `busy` and `dut_sram_write_enable` for the duration of the job.

Parameters:
WIDTH, 16, SRAM word width; also the maximum image dimension N.
ADDR_W, 12, SRAM address width.
OUT_BASE, 12'h100, address of output row 0.

Ports:
clk  input  1  system clock
reset_b  input  1  asynchronous active-low reset
go  input  1  start request; sampled only in IDLE
weights  input  9  kernel; bit 3*i+j = window row i (0 = oldest), column offset j; latched on accepted go
busy  output  1  high from the cycle after go is accepted until done
done  output  1  one-cycle pulse at job end
err  output  1  sticky invalid-dimension flag; cleared on next accepted go
dut_sram_read_address  output  ADDR_W  registered read address
sram_dut_read_data  input  WIDTH  read data, valid 1 cycle after address
dut_sram_write_address  output  ADDR_W  write address
dut_sram_write_data  output  WIDTH  packed output row
dut_sram_write_enable  output  1  one-cycle write strobe

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE. All outputs 0, including busy, done, err, addresses, write data and write enable. Reset mid-job aborts immediately; no partial write completes.
- Memory map: address 0 holds N in bits [4:0]. Addresses 1..N hold image rows 0..N-1. Bit c of a row word is column c.
- FSM states: IDLE, DIM_RD, DIM_CAP, ROW_RD, ROW_CAP, WRITE, DONE.
  - IDLE: when go=1, latch weights, clear err, go to DIM_RD. go is ignored in every other state.
  - DIM_RD: read address = 0.
  - DIM_CAP: capture N.
    - If N<3 or N>WIDTH: set err and go to DONE with no reads and no writes.
    - Otherwise go to ROW_RD.
  - ROW_RD: read address = row index + 1.
  - ROW_CAP: shift the captured word into a 3-row window (w0 = oldest, w2 = newest) and increment the row count.
    - If fewer than 3 rows are loaded, go to ROW_RD.
    - Otherwise go to WRITE.
  - WRITE: for output row r = rows_loaded - 3, assert write enable for exactly 1 cycle with address OUT_BASE + r and the computed data.
    - If r == N-3, go to DONE.
    - Otherwise go to ROW_RD.
  - DONE: done=1 for 1 cycle, busy drops in the same cycle, then return to IDLE.
- Compute (combinational from window and latched weights):
  - For output column c in 0..N-3: m = count of i,j in {0,1,2} where w_i[c+j] XNOR weights[3i+j] is 1 (0..9).
  - out[c] = 1 if m >= 5.
  - Bits N-2..WIDTH-1 of the write data are 0.
- Latency:
  - Valid job: busy high for exactly 3N+1 cycles (2 dim + 2N read + (N-2) write + 1 done). N=4 gives 13 cycles.
  - Invalid N: busy high for exactly 3 cycles.
- Write data and write address are held at 0 whenever write enable is 0.
- err stays high after DONE until the next accepted go.

Optional Feature:
Macro BCONV_THRESHOLD_EN.
- Defined: adds input port `threshold` (4 bits), latched with weights on go. out[c] = 1 iff m >= threshold; threshold = 0 forces every valid column to 1.
- Undefined: the port is absent and the threshold is fixed at 5.

Test Plan:
- N=4, rows all 16'hFFFF, weights 9'h1FF -> writes 16'h0003 to 0x100 and 0x101; busy high for 13 cycles; one done pulse; err=0.
- N=4, rows all 16'hFFFF, weights 9'h000 -> writes 16'h0000 to 0x100 and 0x101.
- N=8, rows alternating 16'h5555/16'hAAAA starting with 5555, weights 9'h155 -> 0x100=16'h0015, 0x101=16'h002A, pattern alternating through 0x105; busy high for 25 cycles.
- Word 0 = 2 (also repeat with 17) -> err=1, done pulse, no write strobes, busy high for 3 cycles; next go clears err.
- go pulsed repeatedly during a job -> no second job starts and output is identical to a single run; reset_b low during WRITE -> all outputs 0 immediately and FSM in IDLE.
- With BCONV_THRESHOLD_EN: N=4, all-ones image, weights 9'h0F0 (m=4), threshold 4 -> 16'h0003; threshold 5 -> 16'h0000.
